// File: rtl/ofdm_preamble_insert.sv
// TX burst framer: programmable short-training preamble, payload pass-through, trailing zero gap.
// States: IDLE (one bubble, latch shadows) | PREAMBLE (table replay) | PAYLOAD (pass-through) | GAP (zeros)
module ofdm_preamble_insert #(
    parameter logic [7:0] SR_SHORT_LEN = 8'd129,
    parameter logic [7:0] SR_NUM_SHORT = 8'd130,
    parameter logic [7:0] SR_GAP_LEN   = 8'd131,
    parameter logic [7:0] SR_TBL_ADDR  = 8'd132,
    parameter logic [7:0] SR_TBL_DATA  = 8'd133,
    parameter int         TBL_AWIDTH   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        sof,
    output logic        eof
);
    localparam int DEPTH = 1 << TBL_AWIDTH;
    localparam logic [TBL_AWIDTH:0]   MAX_SHORT = (TBL_AWIDTH+1)'(DEPTH);
    localparam logic [TBL_AWIDTH:0]   ONE_S     = (TBL_AWIDTH+1)'(1);
    localparam logic [TBL_AWIDTH-1:0] ONE_P     = TBL_AWIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [TBL_AWIDTH:0] short_len_q;
    logic [7:0]          num_short_q;
    logic [15:0]         gap_len_q;
    logic [TBL_AWIDTH-1:0] tbl_ptr_q;
    logic [31:0]         tbl_q [DEPTH];

    logic [TBL_AWIDTH:0] w_short_q, w_short_d;
    logic [7:0]          w_num_q, w_num_d;
    logic [15:0]         w_gap_q, w_gap_d;
    logic [TBL_AWIDTH:0] sym_idx_q, sym_idx_d;
    logic [7:0]          rep_q, rep_d;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic                first_q, first_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            short_len_q <= (TBL_AWIDTH+1)'(16);
            num_short_q <= 8'd10;
            gap_len_q   <= 16'd0;
            tbl_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else if (set_stb) begin
            case (set_addr)
                SR_SHORT_LEN: short_len_q <= set_data[TBL_AWIDTH:0];
                SR_NUM_SHORT: num_short_q <= set_data[7:0];
                SR_GAP_LEN:   gap_len_q   <= set_data[15:0];
                SR_TBL_ADDR:  tbl_ptr_q   <= set_data[TBL_AWIDTH-1:0];
                SR_TBL_DATA: begin
                    tbl_q[tbl_ptr_q] <= set_data;
                    tbl_ptr_q        <= tbl_ptr_q + ONE_P;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            w_short_q <= '0;
            w_num_q   <= '0;
            w_gap_q   <= '0;
            sym_idx_q <= '0;
            rep_q     <= '0;
            gap_cnt_q <= '0;
            first_q   <= 1'b0;
        end else if (clear) begin
            state_q   <= S_IDLE;
            sym_idx_q <= '0;
            rep_q     <= '0;
            gap_cnt_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_short_q <= w_short_d;
            w_num_q   <= w_num_d;
            w_gap_q   <= w_gap_d;
            sym_idx_q <= sym_idx_d;
            rep_q     <= rep_d;
            gap_cnt_q <= gap_cnt_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        w_short_d = w_short_q;
        w_num_d   = w_num_q;
        w_gap_d   = w_gap_q;
        sym_idx_d = sym_idx_q;
        rep_d     = rep_q;
        gap_cnt_d = gap_cnt_q;
        first_d   = first_q;
        o_tdata   = '0;
        o_tlast   = 1'b0;
        o_tvalid  = 1'b0;
        i_tready  = 1'b0;
        sof       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_tvalid) begin
                    w_short_d = (short_len_q > MAX_SHORT) ? MAX_SHORT : short_len_q;
                    w_num_d   = num_short_q;
                    w_gap_d   = gap_len_q;
                    sym_idx_d = '0;
                    rep_d     = '0;
                    gap_cnt_d = '0;
                    // first_q marks that sof belongs to the first payload beat
                    if (short_len_q != '0 && num_short_q != 8'd0) begin
                        state_d = S_PREAMBLE;
                        first_d = 1'b0;
                    end else begin
                        state_d = S_PAYLOAD;
                        first_d = 1'b1;
                    end
                end
            end
            S_PREAMBLE: begin
                o_tvalid = 1'b1;
                o_tdata  = tbl_q[sym_idx_q[TBL_AWIDTH-1:0]];
                sof      = (sym_idx_q == '0) && (rep_q == 8'd0);
                if (o_tready) begin
                    if (sym_idx_q == w_short_q - ONE_S) begin
                        sym_idx_d = '0;
                        if (rep_q == w_num_q - 8'd1) begin
                            rep_d   = '0;
                            state_d = S_PAYLOAD;
                        end else begin
                            rep_d = rep_q + 8'd1;
                        end
                    end else begin
                        sym_idx_d = sym_idx_q + ONE_S;
                    end
                end
            end
            S_PAYLOAD: begin
                o_tvalid = i_tvalid;
                o_tdata  = i_tdata;
                i_tready = o_tready;
                sof      = first_q && i_tvalid;
                o_tlast  = i_tvalid && i_tlast && (w_gap_q == 16'd0);
                if (i_tvalid && o_tready) begin
                    first_d = 1'b0;
                    if (i_tlast) begin
                        gap_cnt_d = '0;
                        state_d   = (w_gap_q == 16'd0) ? S_IDLE : S_GAP;
                    end
                end
            end
            S_GAP: begin
                o_tvalid = 1'b1;
                o_tlast  = (gap_cnt_q == w_gap_q - 16'd1);
                if (o_tready) begin
                    if (gap_cnt_q == w_gap_q - 16'd1) state_d = S_IDLE;
                    else gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign eof = o_tlast;

endmodule

// File: tb/tb_ofdm_preamble_insert.sv
// Bench for ofdm_preamble_insert: expected bursts are queued as packets are offered and checked beat by beat.
module tb_ofdm_preamble_insert;
    logic        clk = 1'b0;
    logic        reset, clear, set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready, sof, eof;

    ofdm_preamble_insert dut (
        .clk(clk), .reset(reset), .clear(clear),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .sof(sof), .eof(eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        s;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] in_q[$];
    int n_vec = 0, n_err = 0;
    int beats = 0, cyc = 0, last_cyc = -1, sof_gap = -1;
    logic rdy_rand = 1'b0;
    logic hold_v = 1'b0, hold_l, hold_s;
    logic [31:0] hold_d;
    logic [31:0] tbl_m [64];
    int m_short = 16, m_num = 10, m_gap = 0, m_ptr = 0;

    task automatic drive();
        i_tvalid = (in_q.size() > 0);
        if (in_q.size() > 0) {i_tlast, i_tdata} = in_q[0];
        else begin
            i_tlast = 1'b0;
            i_tdata = '0;
        end
        o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: observe at the falling edge, then drive just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (hold_v) begin
            n_vec++;
            if ({o_tvalid, o_tdata, o_tlast, sof} !== {1'b1, hold_d, hold_l, hold_s}) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b s=%b want v=1 d=%h l=%b s=%b",
                         cyc, o_tvalid, o_tdata, o_tlast, sof, hold_d, hold_l, hold_s);
            end
        end
        hold_v = o_tvalid && !o_tready;
        hold_d = o_tdata;
        hold_l = o_tlast;
        hold_s = sof;
        if (o_tvalid && o_tready) begin
            beats++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_beat cyc=%0d got d=%h last=%b sof=%b want no beat",
                         cyc, o_tdata, o_tlast, sof);
            end else begin
                e = exp_q.pop_front();
                if (o_tdata !== e.d || o_tlast !== e.l || sof !== e.s || eof !== e.l) begin
                    n_err++;
                    $display("FAIL beat%0d got d=%h last=%b sof=%b eof=%b want d=%h last=%b sof=%b eof=%b",
                             beats, o_tdata, o_tlast, sof, eof, e.d, e.l, e.s, e.l);
                end
            end
            if (sof && last_cyc >= 0) sof_gap = cyc - last_cyc;
            if (o_tlast) last_cyc = cyc;
        end
        if (i_tvalid && i_tready) void'(in_q.pop_front());
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic set_reg(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        step();
        set_stb = 1'b0;
        case (addr)
            8'd129: m_short = int'(data[6:0]);
            8'd130: m_num   = int'(data[7:0]);
            8'd131: m_gap   = int'(data[15:0]);
            8'd132: m_ptr   = int'(data[5:0]);
            8'd133: begin
                tbl_m[m_ptr] = data;
                m_ptr = (m_ptr + 1) % 64;
            end
            default: ;
        endcase
    endtask

    task automatic push_burst(input int n);
        int sl;
        logic first, last;
        logic [31:0] d;
        first = 1'b1;
        sl = (m_short > 64) ? 64 : m_short;
        if (sl != 0 && m_num != 0)
            for (int r = 0; r < m_num; r++)
                for (int k = 0; k < sl; k++) begin
                    exp_q.push_back({tbl_m[k], 1'b0, first});
                    first = 1'b0;
                end
        for (int p = 0; p < n; p++) begin
            d    = $urandom;
            last = (p == n - 1);
            in_q.push_back({last, d});
            exp_q.push_back({d, last && (m_gap == 0), first});
            first = 1'b0;
        end
        for (int g = 0; g < m_gap; g++) exp_q.push_back({32'h0, (g == m_gap - 1), 1'b0});
    endtask

    task automatic drain(input int max, input string name);
        int n = 0;
        while ((exp_q.size() > 0 || in_q.size() > 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout got %0d beats left want 0", name, exp_q.size());
        end
        step();
        step();
    endtask

    task automatic wait_beats(input int target, input string name);
        int n = 0;
        while (beats < target && n < 500) begin
            step();
            n++;
        end
        if (beats < target) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_wait got beats=%0d want %0d", name, beats, target);
        end
    endtask

    task automatic check_beats(input int want, input string name);
        n_vec++;
        if (beats !== want) begin
            n_err++;
            $display("FAIL %s_count got %0d beats want %0d", name, beats, want);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({o_tvalid, i_tready, o_tdata, o_tlast, sof, eof} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b rdy=%b d=%h l=%b sof=%b eof=%b want all 0",
                     o_tvalid, i_tready, o_tdata, o_tlast, sof, eof);
        end
        reset = 1'b0;
        step();
        step();
        n_vec++;
        if ({o_tvalid, i_tready, o_tlast, sof} !== 4'd0) begin
            n_err++;
            $display("FAIL idle_outputs got v=%b rdy=%b l=%b sof=%b want 0", o_tvalid, i_tready, o_tlast, sof);
        end
    endtask

    task automatic test_preamble();
        set_reg(8'd132, 32'd0);
        for (int k = 0; k < 16; k++) set_reg(8'd133, k);
        set_reg(8'd129, 32'd16);
        set_reg(8'd130, 32'd2);
        set_reg(8'd131, 32'd4);
        beats = 0;
        push_burst(8);
        drive();
        drain(500, "preamble");
        check_beats(44, "preamble");
    endtask

    task automatic test_passthrough();
        set_reg(8'd130, 32'd0);
        set_reg(8'd131, 32'd0);
        beats = 0;
        push_burst(5);
        drive();
        drain(200, "passthrough");
        check_beats(5, "passthrough");
    endtask

    task automatic test_stall();
        set_reg(8'd130, 32'd2);
        set_reg(8'd131, 32'd4);
        rdy_rand = 1'b1;
        beats = 0;
        push_burst(8);
        drive();
        drain(2000, "stall");
        rdy_rand = 1'b0;
        drive();
        check_beats(44, "stall");
    endtask

    task automatic test_gap_shadow();
        beats = 0;
        push_burst(8);
        m_gap = 8;
        push_burst(8);
        drive();
        wait_beats(33, "gap_shadow");
        set_reg(8'd131, 32'd8);
        drain(1000, "gap_shadow");
        check_beats(92, "gap_shadow");
    endtask

    task automatic test_back_to_back();
        set_reg(8'd131, 32'd0);
        last_cyc = -1;
        sof_gap  = -1;
        beats    = 0;
        push_burst(3);
        push_burst(3);
        drive();
        drain(500, "b2b");
        check_beats(70, "b2b");
        n_vec++;
        if (sof_gap !== 2) begin
            n_err++;
            $display("FAIL b2b_bubble got tlast-to-sof %0d cycles want 2", sof_gap);
        end
    endtask

    task automatic test_clear();
        int b;
        beats = 0;
        push_burst(4);
        drive();
        wait_beats(5, "clear");
        clear = 1'b1;
        step();
        exp_q.delete();
        in_q.delete();
        hold_v = 1'b0;
        clear  = 1'b0;
        drive();
        #1;
        n_vec++;
        if ({o_tvalid, o_tlast} !== 2'b00) begin
            n_err++;
            $display("FAIL clear_abort got v=%b l=%b want 0 0", o_tvalid, o_tlast);
        end
        b = beats;
        repeat (4) step();
        n_vec++;
        if (beats !== b) begin
            n_err++;
            $display("FAIL clear_quiet got %0d extra beats want 0", beats - b);
        end
        beats = 0;
        push_burst(4);
        drive();
        drain(500, "clear_recover");
        check_beats(36, "clear_recover");
    endtask

    task automatic test_reset_midframe();
        beats = 0;
        push_burst(6);
        drive();
        wait_beats(7, "rst_mid");
        #1;
        n_vec++;
        if (o_tdata !== 32'd7 || o_tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre got v=%b d=%h want v=1 d=00000007", o_tvalid, o_tdata);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({o_tvalid, i_tready, o_tdata, o_tlast, sof} !== 35'd0) begin
            n_err++;
            $display("FAIL rst_mid_async got v=%b rdy=%b d=%h l=%b sof=%b want all 0",
                     o_tvalid, i_tready, o_tdata, o_tlast, sof);
        end
        exp_q.delete();
        in_q.delete();
        hold_v = 1'b0;
        for (int k = 0; k < 64; k++) tbl_m[k] = '0;
        m_short = 16;
        m_num   = 10;
        m_gap   = 0;
        m_ptr   = 0;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_reg(8'd130, 32'd2);
        beats = 0;
        push_burst(6);
        drive();
        drain(500, "rst_recover");
        check_beats(38, "rst_recover");
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        for (int k = 0; k < 64; k++) tbl_m[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_preamble();
        test_passthrough();
        test_stall();
        test_gap_shadow();
        test_back_to_back();
        test_clear();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
